// File: rtl/guess_game_ctrl.sv
// guess_game_ctrl: control FSM for the number-guessing game; synchronises Enter,
// sequences check/decrement of the guess datapath and drives hint/win/lose outputs.
module guess_game_ctrl #(
    parameter int SYNC_STAGES  = 2,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_enter,
    input  logic       i_over,
    input  logic       i_under,
    input  logic       i_equal,
    input  logic       i_out_of_guesses,
    output logic       o_inc_actual,
    output logic       o_dec_guesses,
    output logic       o_over_led,
    output logic       o_under_led,
    output logic       o_win,
    output logic       o_lose,
    output logic [3:0] o_state
);
    localparam int CW = $clog2(BLINK_CYCLES);

    typedef enum logic [3:0] {
        S_SEED     = 4'd0,
        S_SEED_REL = 4'd1,
        S_IDLE     = 4'd2,
        S_CHECK    = 4'd3,
        S_DEC      = 4'd4,
        S_TEST     = 4'd5,
        S_REL      = 4'd6,
        S_WIN      = 4'd7,
        S_LOSE     = 4'd8
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_enter_d;
    logic [CW-1:0]          r_cnt;
    logic                   w_enter_s;
    logic                   w_press;

    assign w_enter_s     = r_sync[SYNC_STAGES-1];
    assign w_press       = w_enter_s & ~r_enter_d;
    assign o_inc_actual  = (r_state == S_SEED);
    assign o_dec_guesses = (r_state == S_DEC);
    assign o_state       = r_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_SEED;
            r_sync      <= '0;
            r_enter_d   <= 1'b0;
            r_cnt       <= '0;
            o_over_led  <= 1'b0;
            o_under_led <= 1'b0;
            o_win       <= 1'b0;
            o_lose      <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_enter};
            r_enter_d <= w_enter_s;
            case (r_state)
                S_SEED:     if (w_press) r_state <= S_SEED_REL;
                S_SEED_REL: if (!w_enter_s) r_state <= S_IDLE;
                S_IDLE:     if (w_press) r_state <= S_CHECK;
                S_CHECK: begin
                    // equality wins even if the datapath also flags over/under
                    if (i_equal) begin
                        r_state     <= S_WIN;
                        o_win       <= 1'b1;
                        r_cnt       <= '0;
                        o_over_led  <= 1'b0;
                        o_under_led <= 1'b0;
                    end else begin
                        o_over_led  <= i_over;
                        o_under_led <= i_under;
                        r_state     <= S_DEC;
                    end
                end
                S_DEC:  r_state <= S_TEST;
                S_TEST: begin
                    r_state <= i_out_of_guesses ? S_LOSE : S_REL;
                    o_lose  <= i_out_of_guesses;
                end
                S_REL:  if (!w_enter_s) r_state <= S_IDLE;
                S_WIN: begin
                    if (r_cnt == CW'(BLINK_CYCLES - 1)) begin
                        r_cnt <= '0;
                        o_win <= ~o_win;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_LOSE: ;
                default: r_state <= S_SEED;
            endcase
        end
    end
endmodule

// File: tb/tb_guess_game_ctrl.sv
// tb_guess_game_ctrl: vector table, corner sequences and a random run against a
// game-level reference model of guess_game_ctrl.
module tb_guess_game_ctrl;
    localparam int SS = 2;
    localparam int BC = 4;

    logic clk = 1'b0, reset_n = 1'b0;
    logic i_enter = 1'b0, i_over = 1'b0, i_under = 1'b0, i_equal = 1'b0, i_oog = 1'b0;
    logic o_inc_actual, o_dec_guesses, o_over_led, o_under_led, o_win, o_lose;
    logic [3:0] o_state;

    guess_game_ctrl #(.SYNC_STAGES(SS), .BLINK_CYCLES(BC)) dut (
        .clk(clk), .reset_n(reset_n), .i_enter(i_enter), .i_over(i_over),
        .i_under(i_under), .i_equal(i_equal), .i_out_of_guesses(i_oog),
        .o_inc_actual(o_inc_actual), .o_dec_guesses(o_dec_guesses),
        .o_over_led(o_over_led), .o_under_led(o_under_led), .o_win(o_win),
        .o_lose(o_lose), .o_state(o_state)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, ndec = 0;
    bit model_on = 0;
    int ms, mg, win_age;
    bit m_ovl, m_unl, m_lose;
    bit h[$];

    typedef struct {
        bit e, ov, un;
        int st;
        bit inc, dec, ovl, unl;
    } vec_t;
    vec_t tv[23];

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ms = 0; mg = 7; win_age = 0; m_ovl = 0; m_unl = 0; m_lose = 0;
        h = {};
        repeat (8) h.push_back(1'b0);
    endtask

    task automatic tick();
        bit e, ov, un, eq, oo, es, p;
        i_oog = (mg == 0);
        e = i_enter; ov = i_over; un = i_under; eq = i_equal; oo = i_oog;
        es = h[8-SS];
        p  = es & ~h[7-SS];
        @(posedge clk);
        h.push_back(e);
        void'(h.pop_front());
        case (ms)
            0: if (p) ms = 1;
            1: if (!es) ms = 2;
            2: if (p) ms = 3;
            3: if (eq) begin ms = 7; win_age = 0; m_ovl = 0; m_unl = 0; end
               else begin m_ovl = ov; m_unl = un; ms = 4; end
            4: begin ms = 5; mg--; end
            5: if (oo) begin ms = 8; m_lose = 1; end else ms = 6;
            6: if (!es) ms = 2;
            7: win_age++;
            default: ;
        endcase
        #1;
        if (o_dec_guesses) ndec++;
        if (model_on) begin
            chk("state", int'(o_state), ms);
            chk("inc_actual", int'(o_inc_actual), int'(ms == 0));
            chk("dec_guesses", int'(o_dec_guesses), int'(ms == 4));
            chk("over_led", int'(o_over_led), int'(m_ovl));
            chk("under_led", int'(o_under_led), int'(m_unl));
            chk("win", int'(o_win), int'(ms == 7 && ((win_age / BC) % 2 == 0)));
            chk("lose", int'(o_lose), int'(m_lose));
        end
    endtask

    task automatic do_reset();
        reset_n = 0; i_enter = 0; i_over = 0; i_under = 0; i_equal = 0; i_oog = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
        model_reset();
        ndec = 0;
    endtask

    task automatic press_guess(int hold, int rel);
        i_enter = 1;
        repeat (hold) tick();
        i_enter = 0;
        repeat (rel) tick();
    endtask

    initial begin
        tv[0]  = '{1,0,0, 0, 1,0, 0,0};
        tv[1]  = '{1,0,0, 0, 1,0, 0,0};
        tv[2]  = '{1,0,0, 1, 0,0, 0,0};
        tv[3]  = '{0,0,0, 1, 0,0, 0,0};
        tv[4]  = '{0,0,0, 1, 0,0, 0,0};
        tv[5]  = '{0,0,0, 2, 0,0, 0,0};
        tv[6]  = '{1,1,0, 2, 0,0, 0,0};
        tv[7]  = '{1,1,0, 2, 0,0, 0,0};
        tv[8]  = '{1,1,0, 3, 0,0, 0,0};
        tv[9]  = '{1,1,0, 4, 0,1, 1,0};
        tv[10] = '{1,1,0, 5, 0,0, 1,0};
        tv[11] = '{0,1,0, 6, 0,0, 1,0};
        tv[12] = '{0,1,0, 6, 0,0, 1,0};
        tv[13] = '{0,1,0, 2, 0,0, 1,0};
        tv[14] = '{1,0,1, 2, 0,0, 1,0};
        tv[15] = '{1,0,1, 2, 0,0, 1,0};
        tv[16] = '{1,0,1, 3, 0,0, 1,0};
        tv[17] = '{1,0,1, 4, 0,1, 0,1};
        tv[18] = '{1,0,1, 5, 0,0, 0,1};
        tv[19] = '{1,0,1, 6, 0,0, 0,1};
        tv[20] = '{0,0,1, 6, 0,0, 0,1};
        tv[21] = '{0,0,1, 6, 0,0, 0,1};
        tv[22] = '{0,0,1, 2, 0,0, 0,1};

        // seed phase with Enter low: must sit in S_SEED pulsing inc_actual
        do_reset();
        model_on = 1;
        repeat (100) tick();
        model_on = 0;

        do_reset();
        for (int i = 0; i < 23; i++) begin
            i_enter = tv[i].e; i_over = tv[i].ov; i_under = tv[i].un;
            tick();
            chk($sformatf("vec%0d_state", i), int'(o_state), tv[i].st);
            chk($sformatf("vec%0d_inc", i), int'(o_inc_actual), int'(tv[i].inc));
            chk($sformatf("vec%0d_dec", i), int'(o_dec_guesses), int'(tv[i].dec));
            chk($sformatf("vec%0d_leds", i), int'({o_over_led, o_under_led}),
                int'({tv[i].ovl, tv[i].unl}));
        end

        // asynchronous reset while the decrement strobe is high
        i_enter = 1;
        for (int k = 0; k < 10 && o_state != 4'd4; k++) tick();
        chk("reach_dec", int'(o_state), 4);
        #2 reset_n = 0;
        #1;
        chk("arst_dec", int'(o_dec_guesses), 0);
        chk("arst_inc", int'(o_inc_actual), 1);
        chk("arst_state", int'(o_state), 0);
        chk("arst_leds", int'({o_over_led, o_under_led, o_win, o_lose}), 0);

        // win after a wrong guess, equal and over asserted together
        do_reset();
        model_on = 1;
        press_guess(3, 3);
        i_over = 1;
        press_guess(4, 4);
        chk("pre_win_over_led", int'(o_over_led), 1);
        ndec = 0;
        i_equal = 1;
        i_enter = 1;
        for (int k = 0; k < 10 && o_state != 4'd7; k++) tick();
        chk("win_state", int'(o_state), 7);
        chk("win_no_dec", ndec, 0);
        chk("win_leds", int'({o_over_led, o_under_led}), 0);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("win_blink%0d", k), int'(o_win), int'((k / 4) % 2 == 0));
            tick();
        end
        i_equal = 0;
        press_guess(4, 4);
        chk("win_hold", int'(o_state), 7);

        // seven wrong guesses lose; later presses ignored
        do_reset();
        press_guess(3, 3);
        i_over = 1;
        repeat (9) press_guess(4, 4);
        chk("lose_state", int'(o_state), 8);
        chk("lose_dec_count", ndec, 7);
        chk("lose_led", int'(o_lose), 1);
        chk("lose_over_led", int'(o_over_led), 1);

        // random games checked cycle by cycle against the model
        for (int g = 0; g < 6; g++) begin
            int hold = 0;
            do_reset();
            for (int n = 0; n < 400; n++) begin
                int r;
                if (hold == 0) begin
                    i_enter = 1'($urandom_range(0, 1));
                    hold = $urandom_range(1, 6);
                end
                hold--;
                r = $urandom_range(0, 11);
                i_equal = (r < 2);
                i_over  = (r == 1) || (r >= 2 && r < 7);
                i_under = (r >= 7);
                tick();
            end
        end
        model_on = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
